imem_loadable: RTL and testbench
================================

# imem_loadable

Parametrised, loadable instruction memory for the single-cycle accumulator processor. Replaces the fixed, initial-block program store with a synchronous-read array, a streaming program-load port with a valid/ready handshake, and an explicit RUN/PROG/DONE controller. The processor fetch stage reads it; a loader (testbench, UART bridge) writes programs at run time.

## Interface

Parameters:
- DATA_W, 8, instruction width (3-bit opcode + 5-bit operand in the default ISA)
- ADDR_W, 5, fetch/write address width
- DEPTH, 32, implemented words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- fetch_req  in  1  read request
- fetch_addr  in  ADDR_W  read address
- fetch_valid  out  1  instruction valid this cycle
- instruction  out  DATA_W  fetched word
- addr_err  out  1  pulse with fetch_valid when fetch_addr ≥ DEPTH
- prog_start  in  1  request to enter load mode
- prog_valid  in  1  loader word valid
- prog_data  in  DATA_W  loader word
- prog_last  in  1  marks final word of the program
- prog_ready  out  1  memory accepts a word
- busy  out  1  high in PROG and DONE
- prog_done  out  1  one-cycle pulse at load completion
- prog_count  out  ADDR_W+1  words written by the most recent load
- inj_par  in  1  parity-inversion hook (only with IMEM_PARITY_EN)
- parity_err  out  1  parity mismatch on fetch (only with IMEM_PARITY_EN)

## Operation

- States: RUN (reset state), PROG, DONE.
- RUN: fetches served. prog_start=1 → PROG; write pointer wptr cleared to 0; prog_count cleared to 0.
- PROG: prog_ready=1. Transfer when prog_valid & prog_ready: mem[wptr] ← prog_data, wptr++, prog_count++. prog_valid low = bubble, nothing advances.
- Exit PROG → DONE on the transfer that has prog_last=1, or on the transfer writing wptr=DEPTH-1 (full); prog_ready falls the next cycle. Words after full are never accepted.
- DONE: lasts one cycle, prog_done=1, prog_ready=0 → RUN.
- prog_start outside RUN ignored. fetch_req in PROG/DONE ignored: no fetch_valid is produced, nothing queued.
- fetch_addr ≥ DEPTH in RUN: instruction=0, fetch_valid=1, addr_err=1.
- Array contents are not reset; unwritten words read undefined. Memory retains contents across rst_n.

## Timing

- Reset values: state RUN, fetch_valid 0, instruction 0, addr_err 0, prog_ready 0, busy 0, prog_done 0, prog_count 0, parity_err 0.
- Fetch latency 1: fetch_req in cycle N (RUN) → instruction, fetch_valid in N+1. Back-to-back requests give one word per cycle. With no request, fetch_valid=0 and instruction holds its last value.
- Load throughput: one word per cycle while prog_valid is held high.
- prog_start in cycle N → prog_ready=1 in N+1.
- Final transfer in cycle M → DONE in M+1 (prog_done=1, busy=1) → RUN in M+2. fetch_req in M+2 is served.
- rst_n asserted mid-load: immediate return to RUN with reset outputs; words already written stay.

## Configuration

- IMEM_PARITY_EN defined: each word stores one extra even-parity bit, computed at write. If inj_par=1 on the transfer, the stored parity is inverted. On each fetch, parity_err=1 alongside fetch_valid when the stored bit mismatches; parity_err=0 on out-of-range fetches.
- Undefined: no parity storage, and the inj_par and parity_err ports do not exist.

## Test plan

- Reset, prog_start, load 00,21,E0,22,E1,43,86 with prog_last on 86 → prog_done in the cycle after 86, prog_count=7. Fetch addresses 0..6 back-to-back → same words, each one cycle later.
- Load 32 words with prog_last never asserted → the 32nd is accepted, prog_ready=0 the next cycle, prog_count=32, and a 33rd offered word is not written.
- Insert bubbles, and assert fetch_req in PROG, during a 4-word load → exactly 4 writes, fetch_valid stays 0 until RUN.
- DEPTH=24: fetch address 30 → instruction=00, fetch_valid=1, addr_err=1. Fetch address 23 → stored word, addr_err=0.
- rst_n low after 3 of 7 words → busy=0, prog_ready=0, prog_count=0. Fetching 0..2 returns the loaded words.
- IMEM_PARITY_EN: write addr 2 with inj_par=1 → fetch 2 gives parity_err=1, while fetch 1 gives parity_err=0.

Source files
------------

// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - loadable instruction memory: synchronous fetch port plus streaming program-load port
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag mismatches on fetch.
module imem_loadable #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              addr_err,
    input  logic              prog_start,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic              busy,
    output logic              prog_done,
    output logic [ADDR_W:0]   prog_count
`ifdef IMEM_PARITY_EN
    ,
    input  logic              inj_par,
    output logic              parity_err
`endif
);
    typedef enum logic [1:0] {RUN, PROG, DONE} state_t;

    localparam int              LAST_I  = DEPTH - 1;
    localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST_W  = LAST_I[ADDR_W:0];

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              fv_q, aerr_q;
    logic [DATA_W-1:0] instr_q;
    logic              wr_en, fetch_en, in_range;

    // Array has no reset so a program survives rst_n.
    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_en    = (state_q == PROG) && prog_valid;
    assign fetch_en = (state_q == RUN) && fetch_req;
    assign in_range = {1'b0, fetch_addr} < DEPTH_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The load count doubles as the write pointer; a load ends on prog_last or when the last word is filled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (prog_start) begin
                    state_d = PROG;
                    cnt_d   = '0;
                end
            end
            PROG: begin
                if (prog_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (prog_last || (cnt_q == LAST_W)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign prog_ready = (state_q == PROG);
    assign busy       = (state_q != RUN);
    assign prog_done  = (state_q == DONE);
    assign prog_count = cnt_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt_q[ADDR_W-1:0]] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_q    <= 1'b0;
            aerr_q  <= 1'b0;
            instr_q <= '0;
        end else begin
            fv_q   <= fetch_en;
            aerr_q <= fetch_en && !in_range;
            if (fetch_en) begin
                instr_q <= in_range ? mem[fetch_addr] : '0;
            end
        end
    end

    assign fetch_valid = fv_q;
    assign addr_err    = aerr_q;
    assign instruction = instr_q;

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic perr_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem[cnt_q[ADDR_W-1:0]] <= (^prog_data) ^ inj_par;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= fetch_en && in_range && ((^mem[fetch_addr]) != par_mem[fetch_addr]);
        end
    end

    assign parity_err = perr_q;
`endif
endmodule

// File: tb/tb_imem_loadable.sv
// tb/tb_imem_loadable.sv - self-checking bench for imem_loadable at DEPTH 32 and DEPTH 24
module tb_imem_loadable;
    localparam int NI = 2;

    typedef struct {
        logic       start, valid;
        logic [7:0] data;
        logic       last, req;
        logic [4:0] addr;
        logic       e_rdy, e_done, e_busy;
        logic [5:0] e_cnt;
        logic       e_fv;
        logic [7:0] e_ins;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch_req, prog_start, prog_valid, prog_last;
    logic [4:0] fetch_addr;
    logic [7:0] prog_data;

    logic       fv  [NI];
    logic [7:0] ins [NI];
    logic       ae  [NI];
    logic       rdy [NI];
    logic       bsy [NI];
    logic       dn  [NI];
    logic [5:0] cnt [NI];
`ifdef IMEM_PARITY_EN
    logic       inj_s;
    logic       pe    [NI];
    bit         m_inj [NI][32];
    bit         m_pe  [NI];
`endif

    int n_vec = 0;
    int n_err = 0;
    int dep [NI] = '{32, 24};

    logic [7:0] m_mem   [NI][32];
    bit         m_known [NI][32];
    bit         m_ld [NI], m_dn [NI], m_fv [NI], m_ae [NI], m_ik [NI];
    int         m_cnt [NI];
    logic [7:0] m_ins [NI];

    logic [7:0] prg [7] = '{8'h00, 8'h21, 8'hE0, 8'h22, 8'hE1, 8'h43, 8'h86};
    logic [7:0] wf  [33];
    logic [7:0] w3  [3];
    vec_t       tbl [17];

    imem_loadable #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) u32 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fv[0]), .instruction(ins[0]), .addr_err(ae[0]),
        .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_last(prog_last), .prog_ready(rdy[0]), .busy(bsy[0]),
        .prog_done(dn[0]), .prog_count(cnt[0])
`ifdef IMEM_PARITY_EN
        , .inj_par(inj_s), .parity_err(pe[0])
`endif
    );

    imem_loadable #(.DATA_W(8), .ADDR_W(5), .DEPTH(24)) u24 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fv[1]), .instruction(ins[1]), .addr_err(ae[1]),
        .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_last(prog_last), .prog_ready(rdy[1]), .busy(bsy[1]),
        .prog_done(dn[1]), .prog_count(cnt[1])
`ifdef IMEM_PARITY_EN
        , .inj_par(inj_s), .parity_err(pe[1])
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [depth %0d] at %0t: got %0h, expected %0h", nm, dep[k], $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic v, input logic [7:0] d, input logic l,
                                input logic r, input logic [4:0] a, input logic er, input logic ed,
                                input logic eb, input logic [5:0] ec, input logic ef, input logic [7:0] ei);
        vec_t t;
        t.start = st; t.valid = v; t.data = d; t.last = l; t.req = r; t.addr = a;
        t.e_rdy = er; t.e_done = ed; t.e_busy = eb; t.e_cnt = ec; t.e_fv = ef; t.e_ins = ei;
        return t;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_ld[k] = 0; m_dn[k] = 0; m_fv[k] = 0; m_ae[k] = 0;
            m_cnt[k] = 0; m_ins[k] = 8'h00; m_ik[k] = 1;
`ifdef IMEM_PARITY_EN
            m_pe[k] = 0;
`endif
        end
    endtask

    // Reference behaviour for one rising edge, from the current inputs.
    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            bit run;
            run = !m_ld[k] && !m_dn[k];
            m_fv[k] = run && fetch_req;
            m_ae[k] = m_fv[k] && (int'(fetch_addr) >= dep[k]);
`ifdef IMEM_PARITY_EN
            m_pe[k] = m_fv[k] && !m_ae[k] && m_inj[k][fetch_addr];
`endif
            if (m_fv[k]) begin
                if (m_ae[k]) begin
                    m_ins[k] = 8'h00;
                    m_ik[k]  = 1;
                end else begin
                    m_ins[k] = m_mem[k][fetch_addr];
                    m_ik[k]  = m_known[k][fetch_addr];
                end
            end
            if (m_dn[k]) begin
                m_dn[k] = 0;
            end else if (m_ld[k]) begin
                if (prog_valid) begin
                    m_mem[k][m_cnt[k]]   = prog_data;
                    m_known[k][m_cnt[k]] = 1;
`ifdef IMEM_PARITY_EN
                    m_inj[k][m_cnt[k]]   = inj_s;
`endif
                    m_cnt[k]++;
                    if (prog_last || m_cnt[k] == dep[k]) begin
                        m_ld[k] = 0;
                        m_dn[k] = 1;
                    end
                end
            end else if (prog_start) begin
                m_ld[k]  = 1;
                m_cnt[k] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            chk("prog_ready",  k, rdy[k], m_ld[k]);
            chk("busy",        k, bsy[k], m_ld[k] | m_dn[k]);
            chk("prog_done",   k, dn[k],  m_dn[k]);
            chk("prog_count",  k, cnt[k], m_cnt[k]);
            chk("fetch_valid", k, fv[k],  m_fv[k]);
            chk("addr_err",    k, ae[k],  m_ae[k]);
            if (m_ik[k]) chk("instruction", k, ins[k], m_ins[k]);
`ifdef IMEM_PARITY_EN
            if (!m_fv[k] || m_ik[k]) chk("parity_err", k, pe[k], m_pe[k]);
`endif
        end
    endtask

    task automatic step(input logic st, input logic v, input logic [7:0] d, input logic l,
                        input logic r, input logic [4:0] a);
        prog_start = st; prog_valid = v; prog_data = d; prog_last = l;
        fetch_req = r; fetch_addr = a;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int acc;
        int guard;

        rst_n = 1'b0;
        prog_start = 0; prog_valid = 0; prog_data = 0; prog_last = 0;
        fetch_req = 0; fetch_addr = 0;
`ifdef IMEM_PARITY_EN
        inj_s = 0;
        for (int k = 0; k < NI; k++) for (int a = 0; a < 32; a++) m_inj[k][a] = 0;
`endif
        for (int k = 0; k < NI; k++) for (int a = 0; a < 32; a++) begin
            m_known[k][a] = 0;
            m_mem[k][a]   = 8'h00;
        end
        model_reset();
        #12;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed 7-word load then back-to-back fetch of the same words.
        tbl[0] = mk(1, 0, 8'h00, 0, 0, 5'd0, 1, 0, 1, 6'd0, 0, 8'h00);
        for (int i = 1; i <= 7; i++)
            tbl[i] = mk(0, 1, prg[i-1], (i == 7), 0, 5'd0, (i != 7), (i == 7), 1, 6'(i), 0, 8'h00);
        tbl[8] = mk(0, 0, 8'h00, 0, 0, 5'd0, 0, 0, 0, 6'd7, 0, 8'h00);
        for (int i = 9; i <= 15; i++)
            tbl[i] = mk(0, 0, 8'h00, 0, 1, 5'(i - 9), 0, 0, 0, 6'd7, 1, prg[i-9]);
        tbl[16] = mk(0, 0, 8'h00, 0, 0, 5'd0, 0, 0, 0, 6'd7, 0, 8'h86);
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].start, tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].req, tbl[i].addr);
            chk($sformatf("tbl%0d_ready", i), 0, rdy[0], tbl[i].e_rdy);
            chk($sformatf("tbl%0d_done",  i), 0, dn[0],  tbl[i].e_done);
            chk($sformatf("tbl%0d_busy",  i), 0, bsy[0], tbl[i].e_busy);
            chk($sformatf("tbl%0d_count", i), 0, cnt[0], tbl[i].e_cnt);
            chk($sformatf("tbl%0d_valid", i), 0, fv[0],  tbl[i].e_fv);
            chk($sformatf("tbl%0d_instr", i), 0, ins[0], tbl[i].e_ins);
        end

        // 33 words without prog_last: the 32nd fills memory, the 33rd is refused.
        for (int i = 0; i < 33; i++) wf[i] = 8'($urandom);
        step(1, 0, 8'h00, 0, 0, 5'd0);
        for (int i = 0; i < 33; i++) begin
            step(0, 1, wf[i], 0, 0, 5'd0);
            if (i == 31) begin
                chk("full_ready", 0, rdy[0], 1'b0);
                chk("full_count", 0, cnt[0], 6'd32);
            end
        end
        for (int a = 0; a < 32; a++) begin
            step(0, 0, 8'h00, 0, 1, 5'(a));
            chk("full_word", 0, ins[0], wf[a]);
        end
        chk("full_count_after", 1, cnt[1], 6'd24);

        // Out-of-range and last in-range address on the 24-word instance.
        step(0, 0, 8'h00, 0, 1, 5'd30);
        chk("oor_instr", 1, ins[1], 8'h00);
        chk("oor_valid", 1, fv[1], 1'b1);
        chk("oor_err",   1, ae[1], 1'b1);
        step(0, 0, 8'h00, 0, 1, 5'd23);
        chk("top_instr", 1, ins[1], wf[23]);
        chk("top_err",   1, ae[1], 1'b0);

        // 4-word load with bubbles and fetch requests during PROG.
        step(1, 0, 8'h00, 0, 1, 5'd3);
        acc = 0;
        guard = 0;
        while (acc < 4 && guard < 200) begin
            logic v;
            v = 1'($urandom);
            step(0, v, 8'($urandom), v && (acc == 3), 1, 5'($urandom));
            if (v) acc++;
            guard++;
        end
        chk("bubble_done_in_budget", 0, guard < 200, 1'b1);
        chk("bubble_count", 0, cnt[0], 6'd4);
        step(0, 0, 8'h00, 0, 1, 5'd1);
        chk("bubble_no_fetch_in_done", 0, fv[0], 1'b0);
        step(0, 0, 8'h00, 0, 1, 5'd2);
        chk("bubble_fetch_in_run", 0, fv[0], 1'b1);

        // Reset after 3 of 7 words.
        step(1, 0, 8'h00, 0, 0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            w3[i] = 8'($urandom);
            step(0, 1, w3[i], 0, 0, 5'd0);
        end
        prog_valid = 0;
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        chk("rst_busy",  0, bsy[0], 1'b0);
        chk("rst_ready", 0, rdy[0], 1'b0);
        chk("rst_count", 0, cnt[0], 6'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 3; a++) begin
            step(0, 0, 8'h00, 0, 1, 5'(a));
            chk("rst_kept_word", 0, ins[0], w3[a]);
        end

`ifdef IMEM_PARITY_EN
        step(1, 0, 8'h00, 0, 0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            inj_s = (i == 2);
            step(0, 1, 8'($urandom), (i == 3), 0, 5'd0);
        end
        inj_s = 0;
        step(0, 0, 8'h00, 0, 0, 5'd0);
        step(0, 0, 8'h00, 0, 1, 5'd2);
        chk("parity_injected", 0, pe[0], 1'b1);
        step(0, 0, 8'h00, 0, 1, 5'd1);
        chk("parity_clean", 0, pe[0], 1'b0);
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) == 0, 1'($urandom), 8'($urandom), ($urandom % 8) == 0,
                 1'($urandom), 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
